// File: rtl/unary_reduce_arb_if.sv
`default_nettype none
// ============================================================================
// Module   : unary_reduce_arb_if
// Brief    : Request/response bundle between two requesters, a consumer and
//            the shared unary/reduction unit.
// Revision : 1.0 - initial release
// ============================================================================
interface unary_reduce_arb_if;
    logic       req0_valid;
    logic [2:0] req0_op;
    logic [7:0] req0_a;
    logic       req0_ready;

    logic       req1_valid;
    logic [2:0] req1_op;
    logic [7:0] req1_a;
    logic       req1_ready;

    logic       rsp_valid;
    logic       rsp_id;
    logic [7:0] rsp_data;
    logic       rsp_ready;

    // Requesters and result consumer
    modport master (
        output req0_valid, req0_op, req0_a,
        input  req0_ready,
        output req1_valid, req1_op, req1_a,
        input  req1_ready,
        input  rsp_valid, rsp_id, rsp_data,
        output rsp_ready
    );

    // Shared execution unit
    modport slave (
        input  req0_valid, req0_op, req0_a,
        output req0_ready,
        input  req1_valid, req1_op, req1_a,
        output req1_ready,
        output rsp_valid, rsp_id, rsp_data,
        input  rsp_ready
    );
endinterface
`default_nettype wire

// File: rtl/unary_reduce_arb.sv
`default_nettype none
// ============================================================================
// Module   : unary_reduce_arb
// Brief    : One 8-bit unary/reduction unit shared by two requesters through a
//            round-robin IDLE/EXEC/RESP controller.
// Revision : 1.0 - initial release
// ============================================================================
module unary_reduce_arb #(
    parameter int COUNT_W = 16
) (
    input  wire logic               clk,
    input  wire logic               rst,
    unary_reduce_arb_if.slave       bus,
    output logic                    busy,
    output logic [COUNT_W-1:0]      ops_count
);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_EXEC = 2'd1;
    localparam logic [1:0] c_ST_RESP = 2'd2;

    localparam logic [COUNT_W-1:0] c_CNT_ONE = {{(COUNT_W-1){1'b0}}, 1'b1};

    logic [1:0]         r_state;
    logic               r_last_grant;
    logic [2:0]         r_op;
    logic [7:0]         r_a;
    logic               r_id;
    logic               r_rsp_valid;
    logic               r_rsp_id;
    logic [7:0]         r_rsp_data;
    logic [COUNT_W-1:0] r_ops_count;

    logic               w_idle;
    logic               w_grant0;
    logic               w_grant1;
    logic               w_ready0;
    logic               w_ready1;
    logic               w_accept;
    logic [7:0]         w_result;

    function automatic logic [7:0] f_compute(input logic [2:0] op, input logic [7:0] a);
        logic [7:0] v;
        v = 8'h00;
        case (op)
            3'b000:  v = ~a;
            3'b001:  v = {7'b0, ~&a};
            3'b010:  v = {7'b0, ~|a};
            3'b011:  v = {7'b0, &(~a)};
            3'b100:  v = {7'b0, |(~a)};
            3'b101:  v = {7'b0, ^a};
            3'b110:  v = {7'b0, &a};
            default: v = {7'b0, |a};
        endcase
        return v;
    endfunction

    // On contention the requester that did not win last time is granted.
    assign w_idle   = (r_state == c_ST_IDLE);
    assign w_grant0 = bus.req0_valid && (!bus.req1_valid || r_last_grant);
    assign w_grant1 = bus.req1_valid && (!bus.req0_valid || !r_last_grant);
    assign w_ready0 = w_idle && !rst && w_grant0;
    assign w_ready1 = w_idle && !rst && w_grant1;
    assign w_accept = w_ready0 || w_ready1;
    assign w_result = f_compute(r_op, r_a);

    assign bus.req0_ready = w_ready0;
    assign bus.req1_ready = w_ready1;
    assign bus.rsp_valid  = r_rsp_valid;
    assign bus.rsp_id     = r_rsp_id;
    assign bus.rsp_data   = r_rsp_data;
    assign busy           = !w_idle;
    assign ops_count      = r_ops_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= c_ST_IDLE;
            r_last_grant <= 1'b1;
            r_op         <= 3'b000;
            r_a          <= 8'h00;
            r_id         <= 1'b0;
            r_rsp_valid  <= 1'b0;
            r_rsp_id     <= 1'b0;
            r_rsp_data   <= 8'h00;
            r_ops_count  <= '0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (w_accept) begin
                        r_op         <= w_ready1 ? bus.req1_op : bus.req0_op;
                        r_a          <= w_ready1 ? bus.req1_a  : bus.req0_a;
                        r_id         <= w_ready1;
                        r_last_grant <= w_ready1;
                        r_state      <= c_ST_EXEC;
                    end
                end
                c_ST_EXEC: begin
                    r_rsp_data  <= w_result;
                    r_rsp_id    <= r_id;
                    r_rsp_valid <= 1'b1;
                    r_state     <= c_ST_RESP;
                end
                c_ST_RESP: begin
                    if (bus.rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_ops_count <= r_ops_count + c_CNT_ONE;
                        r_state     <= c_ST_IDLE;
                    end
                end
                default: begin
                    r_rsp_valid <= 1'b0;
                    r_state     <= c_ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_unary_reduce_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_unary_reduce_arb
// Brief    : Directed self-checking bench for unary_reduce_arb (COUNT_W = 2).
// Revision : 1.0 - initial release
// ============================================================================
module tb_unary_reduce_arb;

    logic       clk;
    logic       rst;
    logic       busy;
    logic [1:0] ops_count;

    int         n_total;
    int         n_bad;
    logic [1:0] r_exp_cnt;

    unary_reduce_arb_if bus ();

    unary_reduce_arb #(.COUNT_W(2)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .busy      (busy),
        .ops_count (ops_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.req0_valid = 1'b0;
        bus.req0_op    = 3'b000;
        bus.req0_a     = 8'h00;
        bus.req1_valid = 1'b0;
        bus.req1_op    = 3'b000;
        bus.req1_a     = 8'h00;
    endtask

    // One full transaction from an idle unit with the consumer always ready.
    task automatic run_op(input logic id, input logic [2:0] op, input logic [7:0] a,
                          input logic [7:0] exp_data, input string tag);
        bus.rsp_ready = 1'b1;
        if (id) begin
            bus.req1_valid = 1'b1; bus.req1_op = op; bus.req1_a = a;
        end else begin
            bus.req0_valid = 1'b1; bus.req0_op = op; bus.req0_a = a;
        end
        #1;
        chk({tag, "_ready"}, id ? bus.req1_ready : bus.req0_ready, 1'b1);
        tick();
        // operand scrambled after acceptance must not matter
        bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
        bus.req0_a = ~a; bus.req1_a = ~a;
        #1;
        chk({tag, "_exec_vld"}, bus.rsp_valid, 1'b0);
        chk({tag, "_exec_busy"}, busy, 1'b1);
        tick();
        chk({tag, "_vld"}, bus.rsp_valid, 1'b1);
        chk({tag, "_data"}, bus.rsp_data, exp_data);
        chk({tag, "_id"}, bus.rsp_id, id);
        tick();
        r_exp_cnt = r_exp_cnt + 2'd1;
        chk({tag, "_done_vld"}, bus.rsp_valid, 1'b0);
        chk({tag, "_done_busy"}, busy, 1'b0);
        chk({tag, "_cnt"}, ops_count, r_exp_cnt);
    endtask

    initial begin
        n_total = 0;
        n_bad = 0;
        r_exp_cnt = 2'd0;
        rst = 1'b1;
        bus.rsp_ready = 1'b0;
        idle_inputs();

        // Reset state; ready must stay low while rst is high
        tick();
        bus.req0_valid = 1'b1;
        #1;
        chk("rst_ready0", bus.req0_ready, 1'b0);
        tick();
        chk("rst_vld", bus.rsp_valid, 1'b0);
        chk("rst_id", bus.rsp_id, 1'b0);
        chk("rst_data", bus.rsp_data, 8'h00);
        chk("rst_cnt", ops_count, 2'd0);
        chk("rst_busy", busy, 1'b0);
        idle_inputs();
        rst = 1'b0;

        run_op(1'b0, 3'b001, 8'hFF, 8'h00, "nand_ff");
        run_op(1'b1, 3'b101, 8'hB5, 8'h01, "xor_b5");
        run_op(1'b1, 3'b000, 8'h3C, 8'hC3, "not_3c");
        run_op(1'b0, 3'b011, 8'h00, 8'h01, "andn_00");
        run_op(1'b0, 3'b100, 8'hFF, 8'h00, "orn_ff");
        run_op(1'b1, 3'b110, 8'hFF, 8'h01, "and_ff");
        run_op(1'b0, 3'b111, 8'h00, 8'h00, "or_00");
        run_op(1'b1, 3'b010, 8'h01, 8'h00, "nor_01");
        run_op(1'b0, 3'b001, 8'h7F, 8'h01, "nand_7f");

        // Contention right after reset: req0 first, then req1
        rst = 1'b1;
        tick();
        rst = 1'b0;
        r_exp_cnt = 2'd0;
        bus.rsp_ready = 1'b1;
        bus.req0_valid = 1'b1; bus.req0_op = 3'b010; bus.req0_a = 8'h00;
        bus.req1_valid = 1'b1; bus.req1_op = 3'b010; bus.req1_a = 8'h00;
        #1;
        chk("arb_r0_first", bus.req0_ready, 1'b1);
        chk("arb_r1_wait", bus.req1_ready, 1'b0);
        tick();
        chk("arb_exec_r1", bus.req1_ready, 1'b0);
        tick();
        chk("arb_rsp0_id", bus.rsp_id, 1'b0);
        chk("arb_rsp0_data", bus.rsp_data, 8'h01);
        tick();
        chk("arb_r1_turn", bus.req1_ready, 1'b1);
        chk("arb_r0_held", bus.req0_ready, 1'b0);
        tick();
        idle_inputs();
        tick();
        chk("arb_rsp1_id", bus.rsp_id, 1'b1);
        chk("arb_rsp1_data", bus.rsp_data, 8'h01);
        tick();
        chk("arb_cnt", ops_count, 2'd2);
        r_exp_cnt = 2'd2;

        // Back-pressure: response held for 5 cycles
        bus.rsp_ready = 1'b0;
        bus.req0_valid = 1'b1; bus.req0_op = 3'b111; bus.req0_a = 8'h80;
        tick();
        bus.req0_op = 3'b000; bus.req0_a = 8'h00;
        tick();
        for (int i = 0; i < 5; i++) begin
            chk("bp_vld", bus.rsp_valid, 1'b1);
            chk("bp_data", bus.rsp_data, 8'h01);
            chk("bp_ready0", bus.req0_ready, 1'b0);
            chk("bp_busy", busy, 1'b1);
            tick();
        end
        bus.rsp_ready = 1'b1;
        tick();
        idle_inputs();
        #1;
        r_exp_cnt = r_exp_cnt + 2'd1;
        chk("bp_rel_vld", bus.rsp_valid, 1'b0);
        chk("bp_rel_busy", busy, 1'b0);
        chk("bp_rel_cnt", ops_count, r_exp_cnt);

        // Reset during EXEC abandons the operation
        bus.req1_valid = 1'b1; bus.req1_op = 3'b000; bus.req1_a = 8'h55;
        tick();
        idle_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_vld", bus.rsp_valid, 1'b0);
        chk("abort_busy", busy, 1'b0);
        chk("abort_cnt", ops_count, 2'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("abort_no_rsp", bus.rsp_valid, 1'b0);
        end
        chk("abort_cnt_hold", ops_count, 2'd0);
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        #1;
        chk("abort_lg_r0", bus.req0_ready, 1'b1);
        chk("abort_lg_r1", bus.req1_ready, 1'b0);
        idle_inputs();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/unary_reduce_arb.md
UNARY_REDUCE_ARB -- requirements
Module: unary_reduce_arb

Interface
REQ-001 SHALL have parameter COUNT_W, default 16, width of the completed-operation counter.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port req0_valid  input  1  requester 0 has an operation pending.
REQ-005 SHALL have port req0_op  input  3  requester 0 opcode.
REQ-006 SHALL have port req0_a  input  8  requester 0 operand.
REQ-007 SHALL have port req0_ready  output  1  requester 0 operation accepted this cycle.
REQ-008 SHALL have ports req1_valid, req1_op, req1_a, req1_ready with the same directions, widths and meanings for requester 1.
REQ-009 SHALL have port rsp_valid  output  1  result available.
REQ-010 SHALL have port rsp_id  output  1  index of the requester that owns the result.
REQ-011 SHALL have port rsp_data  output  8  result value.
REQ-012 SHALL have port rsp_ready  input  1  consumer accepts the result.
REQ-013 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-014 SHALL have port ops_count  output  COUNT_W  number of completed response handshakes, modulo 2^COUNT_W.

Function
REQ-015 SHALL share one 8-bit unary/reduction unit between two requesters, using FSM states IDLE, EXEC and RESP.
REQ-016 Opcodes SHALL be: 000 ~a (8-bit); 001 ~&a; 010 ~|a; 011 &(~a); 100 |(~a); 101 ^a; 110 &a; 111 |a; single-bit results placed in rsp_data[0] with bits 7:1 = 0.
REQ-017 In IDLE, grant SHALL be combinational: one valid requester -> that requester; both valid -> requester other than last_grant; none valid -> no grant.
REQ-018 reqN_ready SHALL be 1 only in IDLE for the granted requester; at most one ready per cycle; ready SHALL never be asserted outside IDLE.
REQ-019 On acceptance (reqN_valid && reqN_ready), SHALL latch op, operand and requester id, update last_grant to N, and go to EXEC.
REQ-020 In EXEC, SHALL compute the result from the latched op and operand, register it into rsp_data/rsp_id, and go to RESP next cycle.
REQ-021 In RESP, rsp_valid SHALL be 1; rsp_data and rsp_id SHALL be held stable until rsp_valid && rsp_ready.
REQ-022 On the response handshake, SHALL go to IDLE, deassert rsp_valid next cycle, and increment ops_count by 1, wrapping from 2^COUNT_W-1 to 0.
REQ-023 Latency SHALL be: acceptance in cycle N -> rsp_valid high from cycle N+2; peak throughput one operation per 3 cycles.
REQ-024 A requester dropping valid before acceptance SHALL not be served; operand changes after acceptance SHALL not affect the result.
REQ-025 rsp_valid SHALL remain high indefinitely while rsp_ready is low; no new request SHALL be accepted during that time.
REQ-026 busy SHALL be 1 in EXEC and RESP and 0 in IDLE.

Reset
REQ-027 When rst is high at a clock edge, SHALL enter IDLE, set last_grant = 1 (requester 0 wins the first contention), rsp_valid = 0, rsp_id = 0, rsp_data = 0, ops_count = 0, busy = 0.
REQ-028 Reset asserted in EXEC or RESP SHALL abandon the operation: no response is produced and ops_count is not incremented.
REQ-029 reqN_ready SHALL be 0 in any cycle where rst is high.

Verification
REQ-030 Scenario: req0 op=001, a=8'hFF, rsp_ready=1 -> rsp_valid at accept+2, rsp_data=8'h00, rsp_id=0, ops_count=1.
REQ-031 Scenario: req1 op=101, a=8'hB5, then op=000, a=8'h3C -> rsp_data=8'h01, then 8'hC3, both with rsp_id=1.
REQ-032 Scenario: after reset, req0 and req1 both valid with op=010, a=8'h00 -> req0 accepted first, then req1 accepted in the next IDLE; responses in order id 0 then id 1, both with rsp_data=8'h01.
REQ-033 Scenario: rsp_ready held low for 5 cycles in RESP, with a=8'h80 and op=111 -> rsp_valid stays 1, rsp_data=8'h01 stays stable, req ready stays 0, busy=1; release -> IDLE next cycle.
REQ-034 Scenario: COUNT_W=2, 4 completed operations -> ops_count sequence 1,2,3,0.
REQ-035 Scenario: rst pulsed for 1 cycle while in EXEC -> next cycle IDLE, rsp_valid=0, ops_count=0, and no response is produced for the abandoned operation.
